// File: rtl/ecc_ram_zeroize_pkg.sv
// ecc_ram_zeroize_pkg: shared state encoding for the ECC RAM zeroize sequencer.
package ecc_ram_zeroize_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/ecc_ram_zeroize_seq.sv
// ecc_ram_zeroize_seq: pass-through front end of an ECC true-dual-port RAM that, on request,
// sweeps both ports over the whole array writing zeros (two words per cycle).
module ecc_ram_zeroize_seq
  import ecc_ram_zeroize_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [DATA_WIDTH-1:0] ram_dinb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  busy,
  output logic                  zeroize_done
);
  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-2:0] r_cnt, w_cnt_nxt;
  logic                  r_busy_d1, r_done, w_done_nxt, w_clr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy_d1 <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy_d1 <= w_clr;
      r_done    <= w_done_nxt;
    end
  end
  // A zeroize request always (re)starts the sweep, even on its last cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (zeroize) begin
      w_state_nxt = CLEAR;
      w_cnt_nxt   = '0;
    end else if (r_state == CLEAR) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (&r_cnt) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
    end
  end
  assign w_clr        = (r_state == CLEAR);
  assign busy         = w_clr;
  assign zeroize_done = r_done;
  assign ram_ena      = w_clr | ena;
  assign ram_wea      = w_clr | wea;
  assign ram_addra    = w_clr ? {r_cnt, 1'b0} : addra;
  assign ram_dina     = w_clr ? '0 : dina;
  assign ram_enb      = w_clr | enb;
  assign ram_web      = w_clr | web;
  assign ram_addrb    = w_clr ? {r_cnt, 1'b1} : addrb;
  assign ram_dinb     = w_clr ? '0 : dinb;
  // Read data lags the request by one cycle, so mask one cycle past the sweep too.
  assign douta        = (w_clr | r_busy_d1) ? '0 : ram_douta;
  assign doutb        = (w_clr | r_busy_d1) ? '0 : ram_doutb;
endmodule

// File: tb/tb_ecc_ram_zeroize_seq.sv
// tb_ecc_ram_zeroize_seq: directed checks of pass-through, clear sweep, restart, drop and reset
// behaviour, with a behavioural read-first TDP RAM behind the sequencer.
module tb_ecc_ram_zeroize_seq;
  localparam int AW = 10;
  localparam int DW = 32;
  logic          clk = 1'b0, reset_n = 1'b0, zeroize = 1'b0;
  logic          ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dina = '0, dinb = '0;
  logic [DW-1:0] douta, doutb;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb;
  logic [DW-1:0] ram_douta = '0, ram_doutb = '0;
  logic          busy, zeroize_done;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      ram_douta <= mem[ram_addra];
    end
    if (ram_enb) begin
      if (ram_web) mem[ram_addrb] <= ram_dinb;
      ram_doutb <= mem[ram_addrb];
    end
  end

  ecc_ram_zeroize_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb),
    .busy(busy), .zeroize_done(zeroize_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ram;
    for (int i = 0; i < 512; i++) begin
      ena = 1'b1; wea = 1'b1; addra = AW'(2*i);   dina = 32'hA5A5A5A5;
      enb = 1'b1; web = 1'b1; addrb = AW'(2*i+1); dinb = 32'hA5A5A5A5;
      tick();
    end
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
  endtask

  task automatic pulse_zeroize;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (zeroize_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", zeroize_done); end
    ena = 1'b1; addra = 10'd7; enb = 1'b1; addrb = 10'd9;
    #1;
    total++; if ({ram_ena, ram_addra, ram_enb, ram_addrb} !== {1'b1, 10'd7, 1'b1, 10'd9}) begin
      bad++; $display("FAIL reset_passthru got=%b/%0d/%b/%0d want=1/7/1/9", ram_ena, ram_addra, ram_enb, ram_addrb);
    end
    ena = 1'b0; enb = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_autoclear got=%b want=0", busy); end
  endtask

  task automatic test_passthrough;
    ena = 1'b1; wea = 1'b1; addra = 10'd5; dina = 32'hDEADBEEF;
    enb = 1'b1; web = 1'b1; addrb = 10'd6; dinb = 32'h12345678;
    #1;
    total++; if ({ram_ena, ram_wea, ram_addra, ram_dina} !== {1'b1, 1'b1, 10'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL pass_a got=%b/%b/%0d/%h want=1/1/5/deadbeef", ram_ena, ram_wea, ram_addra, ram_dina);
    end
    total++; if ({ram_enb, ram_web, ram_addrb, ram_dinb} !== {1'b1, 1'b1, 10'd6, 32'h12345678}) begin
      bad++; $display("FAIL pass_b got=%b/%b/%0d/%h want=1/1/6/12345678", ram_enb, ram_web, ram_addrb, ram_dinb);
    end
    tick();
    wea = 1'b0; web = 1'b0;
    tick();
    total++; if (douta !== 32'hDEADBEEF) begin bad++; $display("FAIL pass_read_a got=%h want=deadbeef", douta); end
    total++; if (doutb !== 32'h12345678) begin bad++; $display("FAIL pass_read_b got=%h want=12345678", doutb); end
    ena = 1'b0; enb = 1'b0;
  endtask

  task automatic test_sweep;
    fill_ram();
    pulse_zeroize();
    for (int i = 0; i < 512; i++) begin
      total++; if (busy !== 1'b1 || zeroize_done !== 1'b0) begin
        bad++; $display("FAIL sweep_busy i=%0d got busy=%b done=%b want 1/0", i, busy, zeroize_done);
      end
      total++; if ({ram_addra, ram_addrb} !== {AW'(2*i), AW'(2*i+1)}) begin
        bad++; $display("FAIL sweep_addr i=%0d got=%0d/%0d want=%0d/%0d", i, ram_addra, ram_addrb, 2*i, 2*i+1);
      end
      total++; if ({ram_ena, ram_wea, ram_enb, ram_web, ram_dina, ram_dinb} !== {4'hF, 64'h0}) begin
        bad++; $display("FAIL sweep_wr i=%0d got=%b%b%b%b/%h/%h want=1111/0/0", i, ram_ena, ram_wea, ram_enb, ram_web, ram_dina, ram_dinb);
      end
      total++; if ({douta, doutb} !== 64'h0) begin bad++; $display("FAIL sweep_mask i=%0d got=%h/%h want=0/0", i, douta, doutb); end
      tick();
    end
    total++; if (busy !== 1'b0 || zeroize_done !== 1'b1) begin
      bad++; $display("FAIL sweep_end got busy=%b done=%b want 0/1", busy, zeroize_done);
    end
    total++; if ({douta, doutb} !== 64'h0) begin bad++; $display("FAIL sweep_mask_d1 got=%h/%h want=0/0", douta, doutb); end
    tick();
    total++; if (zeroize_done !== 1'b0) begin bad++; $display("FAIL sweep_done_width got=%b want=0", zeroize_done); end
    for (int i = 0; i <= 512; i++) begin
      if (i > 0) begin
        total++; if ({douta, doutb} !== 64'h0) begin
          bad++; $display("FAIL sweep_read addr=%0d got=%h/%h want=0/0", 2*(i-1), douta, doutb);
        end
      end
      ena = (i < 512); enb = (i < 512); addra = AW'(2*i); addrb = AW'(2*i+1);
      tick();
    end
    ena = 1'b0; enb = 1'b0;
  endtask

  task automatic test_restart;
    int nb, nd;
    nb = 0; nd = 0;
    pulse_zeroize();
    repeat (200) tick();
    total++; if (ram_addra !== 10'd400) begin bad++; $display("FAIL restart_pre got=%0d want=400", ram_addra); end
    pulse_zeroize();
    total++; if (busy !== 1'b1 || ram_addra !== 10'd0) begin
      bad++; $display("FAIL restart_cnt0 got busy=%b addr=%0d want 1/0", busy, ram_addra);
    end
    for (int i = 0; i < 520; i++) begin
      nb += int'(busy);
      nd += int'(zeroize_done);
      tick();
    end
    total++; if (nb != 512) begin bad++; $display("FAIL restart_len got=%0d want=512", nb); end
    total++; if (nd != 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", nd); end
  endtask

  task automatic test_drop;
    fill_ram();
    pulse_zeroize();
    ena = 1'b1; wea = 1'b1; addra = 10'd3; dina = 32'h1;
    for (int i = 0; i <= 512; i++) begin
      total++; if (douta !== 32'h0) begin bad++; $display("FAIL drop_mask i=%0d got=%h want=0", i, douta); end
      if (i < 512) begin
        total++; if (ram_addra !== AW'(2*i) || ram_dina !== 32'h0) begin
          bad++; $display("FAIL drop_req i=%0d got=%0d/%h want=%0d/0", i, ram_addra, ram_dina, 2*i);
        end
      end else begin
        total++; if (busy !== 1'b0 || zeroize_done !== 1'b1) begin
          bad++; $display("FAIL drop_end got busy=%b done=%b want 0/1", busy, zeroize_done);
        end
        ena = 1'b0; wea = 1'b0;
      end
      tick();
    end
    ena = 1'b1; addra = 10'd3;
    tick();
    total++; if (douta !== 32'h0) begin bad++; $display("FAIL drop_read3 got=%h want=0", douta); end
    ena = 1'b0;
  endtask

  task automatic test_reset_mid;
    fill_ram();
    pulse_zeroize();
    repeat (100) tick();
    total++; if (ram_addra !== 10'd200) begin bad++; $display("FAIL rstmid_pre got=%0d want=200", ram_addra); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || zeroize_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got busy=%b done=%b want 0/0", busy, zeroize_done);
    end
    total++; if (ram_ena !== 1'b0 || ram_wea !== 1'b0) begin
      bad++; $display("FAIL rstmid_passthru got=%b/%b want=0/0", ram_ena, ram_wea);
    end
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_resume got=%b want=0", busy); end
    ena = 1'b1; addra = 10'd0; enb = 1'b1; addrb = 10'd1023;
    tick();
    total++; if (douta !== 32'h0) begin bad++; $display("FAIL rstmid_addr0 got=%h want=0", douta); end
    total++; if (doutb !== 32'hA5A5A5A5) begin bad++; $display("FAIL rstmid_addr1023 got=%h want=a5a5a5a5", doutb); end
    ena = 1'b0; enb = 1'b0;
  endtask

  task automatic test_final_restart;
    int n;
    n = 0;
    pulse_zeroize();
    repeat (511) tick();
    total++; if (ram_addra !== 10'd1022) begin bad++; $display("FAIL final_pre got=%0d want=1022", ram_addra); end
    pulse_zeroize();
    total++; if (zeroize_done !== 1'b0 || busy !== 1'b1 || ram_addra !== 10'd0) begin
      bad++; $display("FAIL final_restart got done=%b busy=%b addr=%0d want 0/1/0", zeroize_done, busy, ram_addra);
    end
    while (zeroize_done !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    total++; if (n != 512) begin bad++; $display("FAIL final_len got=%0d want=512", n); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sweep();
    test_restart();
    test_drop();
    test_reset_mid();
    test_final_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecc_ram_zeroize_seq.md
ECC_RAM_ZEROIZE_SEQ -- requirements
Module: ecc_ram_zeroize_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM address width (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port zeroize  input  1  level request to clear the entire RAM.
REQ-006 SHALL have ports ena, wea  input  1 each  upstream port-A enable/write strobe.
REQ-007 SHALL have ports addra  input  ADDR_WIDTH and dina  input  DATA_WIDTH  upstream port-A address/data.
REQ-008 SHALL have port douta  output  DATA_WIDTH  upstream port-A read data.
REQ-009 SHALL have ports enb, web, addrb, dinb (inputs) and doutb (output), same widths, for upstream port B.
REQ-010 SHALL have ports ram_ena, ram_wea, ram_addra, ram_dina (outputs) and ram_douta (input), same widths, to the downstream RAM port A.
REQ-011 SHALL have ports ram_enb, ram_web, ram_addrb, ram_dinb (outputs) and ram_doutb (input), same widths, to the downstream RAM port B.
REQ-012 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-013 SHALL have port zeroize_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-014 SHALL implement FSM states IDLE and CLEAR.
REQ-015 IDLE: all ram_* request outputs SHALL equal the upstream inputs combinationally (zero-latency pass-through).
REQ-016 IDLE with zeroize=1 at a rising edge SHALL move to CLEAR and load sweep counter cnt (ADDR_WIDTH-1 bits) with 0.
REQ-017 CLEAR: SHALL drive ram_ena=ram_enb=ram_wea=ram_web=1, ram_dina=ram_dinb=0, ram_addra={cnt,1'b0}, ram_addrb={cnt,1'b1}.
REQ-018 CLEAR: upstream requests SHALL be ignored (dropped, not queued); cnt SHALL increment by 1 per cycle.
REQ-019 CLEAR with cnt at all-ones SHALL return to IDLE next edge and assert zeroize_done for exactly that one following cycle; sweep length = 2^(ADDR_WIDTH-1) cycles (512 at default).
REQ-020 zeroize=1 while in CLEAR SHALL reset cnt to 0 and keep CLEAR (sweep restarts); this includes the final cnt=all-ones cycle, in which case no done pulse is generated.
REQ-021 zeroize held high continuously SHALL keep the sweep restarting; completion only after zeroize low through a full sweep.
REQ-022 busy SHALL be high exactly when state is CLEAR (registered, no combinational path from zeroize).
REQ-023 douta/doutb SHALL pass ram_douta/ram_doutb through, except forced to 0 when busy or busy_d1 (busy delayed one cycle) is high, covering the RAM's one-cycle read latency.
REQ-024 Upstream request coincident with the zeroize edge in IDLE SHALL still pass through that cycle (state still IDLE); requests from the next cycle are dropped.
REQ-025 Upstream port-A/B address collision handling SHALL be left to the RAM; this block adds none.

Reset
REQ-026 reset_n low SHALL asynchronously force state=IDLE, cnt=0, busy=0, busy_d1=0, zeroize_done=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; RAM contents are then undefined-partially-cleared and the block SHALL NOT auto-resume.
REQ-028 After reset release the block SHALL be in pass-through; no automatic clear on reset exit.

Structure
REQ-029 State enum (IDLE/CLEAR) SHALL live in shared package ecc_ram_zeroize_pkg.
REQ-030 No sub-module SHALL be used; FSM, counter and muxes are flat in this module, instantiated directly upstream of the ECC TDP RAM.

Verification
REQ-031 Reset, then ena=1,wea=1,addra=5,dina=0xDEADBEEF -> ram_* mirrors same cycle; read addr 5 next cycle -> douta=0xDEADBEEF.
REQ-032 Fill RAM with 0xA5A5A5A5, pulse zeroize 1 cycle -> busy high 512 cycles, zeroize_done high cycle 513, all 1024 reads return 0.
REQ-033 Mid-sweep (cnt=200) pulse zeroize -> cnt returns 0, busy lasts 512 more cycles, single done pulse at end.
REQ-034 During CLEAR drive ena=1,wea=1,addra=3,dina=0x1 -> write dropped; after done, read addr 3 -> 0; douta=0 throughout busy and one cycle after.
REQ-035 Assert reset_n low at cnt=100 -> busy=0, zeroize_done=0 immediately (asynchronous), pass-through active after release, addr 0 reads 0, addr 1023 reads prior 0xA5A5A5A5.
REQ-036 zeroize asserted exactly at cnt=511 -> no done pulse that cycle, sweep restarts from 0.
